// File: rtl/transmissor_resposta.sv
// UART 8N1 transmitter for a two-byte response (code byte, then data byte).
// Both bytes go out back-to-back with no idle time between their frames.
module transmissor_resposta #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enviar,
    input  logic [7:0] primeiroByte,
    input  logic [7:0] segundoByte,
    output logic       tx,
    output logic       ocupado,
    output logic       concluido
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} estado_t;

    estado_t          estado, estadoNext;
    logic [CNT_W-1:0] baudCnt, baudCntNext;
    logic [2:0]       bitCnt, bitCntNext;
    logic             byteIdx, byteIdxNext;
    logic [15:0]      shadow, shadowNext;
    logic             txNext, ocupadoNext, concluidoNext;
    logic [7:0]       byteAtual;
    logic             fimBit;

    assign fimBit = (baudCnt == CNT_MAX);

    // Outputs are decoded from the next state so they are registered
    // alongside it and change on the same edge as the state.
    always_comb begin
        estadoNext    = estado;
        baudCntNext   = baudCnt + CNT_W'(1);
        bitCntNext    = bitCnt;
        byteIdxNext   = byteIdx;
        shadowNext    = shadow;
        concluidoNext = 1'b0;

        unique case (estado)
            OCIOSO: begin
                baudCntNext = '0;
                if (enviar) begin
                    shadowNext  = {segundoByte, primeiroByte};
                    byteIdxNext = 1'b0;
                    bitCntNext  = '0;
                    estadoNext  = INICIO;
                end
            end
            INICIO: begin
                if (fimBit) begin
                    baudCntNext = '0;
                    bitCntNext  = '0;
                    estadoNext  = DADOS;
                end
            end
            DADOS: begin
                if (fimBit) begin
                    baudCntNext = '0;
                    if (bitCnt == 3'd7) estadoNext = PARADA;
                    else                bitCntNext = bitCnt + 3'd1;
                end
            end
            PARADA: begin
                if (fimBit) begin
                    baudCntNext = '0;
                    if (!byteIdx) begin
                        byteIdxNext = 1'b1;
                        estadoNext  = INICIO;
                    end else begin
                        estadoNext    = OCIOSO;
                        concluidoNext = 1'b1;
                    end
                end
            end
            default: estadoNext = OCIOSO;
        endcase

        byteAtual = byteIdxNext ? shadowNext[15:8] : shadowNext[7:0];

        txNext      = 1'b1;
        ocupadoNext = 1'b1;
        unique case (estadoNext)
            OCIOSO:  ocupadoNext = 1'b0;
            INICIO:  txNext      = 1'b0;
            DADOS:   txNext      = byteAtual[bitCntNext];
            PARADA:  txNext      = 1'b1;
            default: ocupadoNext = 1'b0;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado    <= OCIOSO;
            baudCnt   <= '0;
            bitCnt    <= '0;
            byteIdx   <= 1'b0;
            shadow    <= '0;
            tx        <= 1'b1;
            ocupado   <= 1'b0;
            concluido <= 1'b0;
        end else begin
            estado    <= estadoNext;
            baudCnt   <= baudCntNext;
            bitCnt    <= bitCntNext;
            byteIdx   <= byteIdxNext;
            shadow    <= shadowNext;
            tx        <= txNext;
            ocupado   <= ocupadoNext;
            concluido <= concluidoNext;
        end
    end

endmodule

// File: tb/tb_transmissor_resposta.sv
// Bench for transmissor_resposta: a line monitor decodes every UART byte and
// compares it against a queue of bytes pushed when each frame is requested.
module tb_transmissor_resposta;

    localparam int CPB = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enviar = 1'b0;
    logic [7:0] primeiroByte = 8'h00;
    logic [7:0] segundoByte = 8'h00;
    logic       tx, ocupado, concluido;

    int         nCompared = 0;
    int         nMismatched = 0;
    int         concCount = 0;
    logic [7:0] sbQ[$];

    transmissor_resposta #(.CLKS_PER_BIT(CPB)) dut (
        .clock(clock), .reset(reset), .enviar(enviar),
        .primeiroByte(primeiroByte), .segundoByte(segundoByte),
        .tx(tx), .ocupado(ocupado), .concluido(concluido)
    );

    always #5 clock = ~clock;

    always @(negedge clock) if (concluido === 1'b1) concCount++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Line monitor: start bit seen at c=0, bits sampled mid-bit every CPB cycles.
    initial begin
        logic [7:0] rx;
        bit         ab;
        forever begin
            @(negedge clock);
            if (!reset && tx === 1'b0) begin
                ab = 1'b0;
                rx = '0;
                for (int c = 1; c <= 38 && !ab; c++) begin
                    @(negedge clock);
                    if (reset) ab = 1'b1;
                    else begin
                        if (c == 2) chk("start bit", 32'(tx), 32'd0);
                        if (c >= 6 && c <= 34 && (c % 4) == 2) rx[(c - 6) / 4] = tx;
                        if (c == 38) chk("stop bit", 32'(tx), 32'd1);
                    end
                end
                if (!ab) begin
                    if (sbQ.size() == 0) chk("unexpected byte on line", 32'(rx), 32'hDEAD);
                    else                 chk("rx byte", 32'(rx), 32'(sbQ.pop_front()));
                end
            end
        end
    end

    // Walk the busy window one negedge at a time; returns its length.
    task automatic measureBusy(input string tag, input int pokeAt, input bit scramble,
                               input bit holdEnv, output int cyc);
        cyc = 0;
        while (ocupado === 1'b1 && cyc < 1000) begin
            if (concluido !== 1'b0) chk({tag, " concluido while busy"}, 32'(concluido), 32'd0);
            cyc++;
            enviar = holdEnv || (cyc == pokeAt);
            if (cyc == pokeAt) begin
                primeiroByte = 8'hFF;
                segundoByte  = 8'hFF;
            end else if (scramble) begin
                primeiroByte = 8'($urandom);
                segundoByte  = 8'($urandom);
            end
            @(negedge clock);
        end
        chk({tag, " busy cycles"}, 32'(cyc), 32'(20 * CPB));
    endtask

    task automatic sendFrame(input string tag, input logic [7:0] p, input logic [7:0] s,
                             input int pokeAt, input bit scramble);
        int cyc, c0;
        @(negedge clock);
        primeiroByte = p;
        segundoByte  = s;
        enviar       = 1'b1;
        sbQ.push_back(p);
        sbQ.push_back(s);
        c0 = concCount;
        @(negedge clock);
        measureBusy(tag, pokeAt, scramble, 1'b0, cyc);
        enviar = 1'b0;
        chk({tag, " concluido at end"}, 32'(concluido), 32'd1);
        @(negedge clock);
        chk({tag, " concluido width"}, 32'(concluido), 32'd0);
        repeat (4) @(negedge clock);
        chk({tag, " concluido pulses"}, 32'(concCount - c0), 32'd1);
        chk({tag, " idle after"}, 32'(ocupado), 32'd0);
        chk({tag, " scoreboard drained"}, 32'(sbQ.size()), 32'd0);
    endtask

    initial begin
        int cyc, c0;

        // Reset behaviour
        repeat (3) @(negedge clock);
        chk("reset tx", 32'(tx), 32'd1);
        chk("reset ocupado", 32'(ocupado), 32'd0);
        chk("reset concluido", 32'(concluido), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            chk("post-reset idle", {29'd0, tx, ocupado, concluido}, 32'b100);
        end

        sendFrame("single 31/50", 8'h31, 8'h50, 0, 1'b0);
        sendFrame("busy reject A5/3C", 8'hA5, 8'h3C, 30, 1'b0);
        sendFrame("input change 6B/D2", 8'h6B, 8'hD2, 0, 1'b1);

        // Back-to-back with enviar held high
        @(negedge clock);
        primeiroByte = 8'h01;
        segundoByte  = 8'h02;
        enviar       = 1'b1;
        sbQ.push_back(8'h01);
        sbQ.push_back(8'h02);
        c0 = concCount;
        @(negedge clock);
        measureBusy("b2b first", 0, 1'b0, 1'b1, cyc);
        chk("b2b concluido 1", 32'(concluido), 32'd1);
        primeiroByte = 8'h03;
        segundoByte  = 8'h04;
        sbQ.push_back(8'h03);
        sbQ.push_back(8'h04);
        @(negedge clock);
        chk("b2b restart ocupado", 32'(ocupado), 32'd1);
        chk("b2b restart start bit", 32'(tx), 32'd0);
        measureBusy("b2b second", 0, 1'b0, 1'b0, cyc);
        enviar = 1'b0;
        chk("b2b concluido 2", 32'(concluido), 32'd1);
        repeat (5) @(negedge clock);
        chk("b2b concluido pulses", 32'(concCount - c0), 32'd2);
        chk("b2b scoreboard drained", 32'(sbQ.size()), 32'd0);

        // Reset during the data bits of the second byte
        @(negedge clock);
        primeiroByte = 8'h99;
        segundoByte  = 8'h66;
        enviar       = 1'b1;
        sbQ.push_back(8'h99);
        sbQ.push_back(8'h66);
        @(negedge clock);
        enviar = 1'b0;
        c0 = concCount;
        repeat (59) @(negedge clock);
        chk("pre-reset busy", 32'(ocupado), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("async reset tx", 32'(tx), 32'd1);
        chk("async reset ocupado", 32'(ocupado), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        sbQ.delete();
        repeat (100) @(negedge clock);
        chk("no concluido after reset", 32'(concCount - c0), 32'd0);
        chk("idle after reset", 32'(ocupado), 32'd0);

        sendFrame("post-reset 5A/C3", 8'h5A, 8'hC3, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
